// File: rtl/streambuf_in.sv
// rtl/streambuf_in.sv - input stream buffer collecting a DEPTH-word frame for parallel hand-off
// Optional STREAMBUF_IN_LAST_EN adds in_last/short_frame for early-terminated, zero-filled frames.
module streambuf_in #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    output logic                                  in_ready,
    output logic                                  frame_valid,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] frame_data,
    input  logic                                  frame_ack,
`ifdef STREAMBUF_IN_LAST_EN
    input  logic                                  in_last,
    output logic                                  short_frame,
`endif
    output logic [ADDR_WIDTH:0]                   count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
    logic [DATA_WIDTH-1:0]   mem_d [DEPTH];
`ifdef STREAMBUF_IN_LAST_EN
    logic                    short_q, short_d;
`endif
    logic                    accept;

    // Gated by rst so the upstream never sees a handshake while reset is held.
    assign in_ready    = (state_q == FILL) && rst;
    assign frame_valid = (state_q == HOLD);
    assign count       = count_q;
    assign accept      = in_valid && in_ready;
`ifdef STREAMBUF_IN_LAST_EN
    assign short_frame = short_q;
`endif

    for (genvar g = 0; g < DEPTH; g++) begin : g_frame
        assign frame_data[g*DATA_WIDTH +: DATA_WIDTH] = mem_q[g];
    end

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        mem_d   = mem_q;
`ifdef STREAMBUF_IN_LAST_EN
        short_d = short_q;
`endif
        case (state_q)
            FILL: begin
                if (accept) begin
                    mem_d[wptr_q] = in_data;
                    wptr_d        = wptr_q + 1'b1;
                    count_d       = count_q + 1'b1;
                    if (wptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_d = HOLD;
                    end
`ifdef STREAMBUF_IN_LAST_EN
                    else if (in_last) begin
                        // Early close: pad the unused tail so the core sees a full frame.
                        for (int i = 0; i < DEPTH; i++) begin
                            if (ADDR_WIDTH'(i) > wptr_q) begin
                                mem_d[i] = '0;
                            end
                        end
                        wptr_d  = '0;
                        count_d = (ADDR_WIDTH+1)'(DEPTH);
                        short_d = 1'b1;
                        state_d = HOLD;
                    end
`endif
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_d = FILL;
                    count_d = '0;
`ifdef STREAMBUF_IN_LAST_EN
                    short_d = 1'b0;
`endif
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            wptr_q  <= '0;
            count_q <= '0;
            mem_q   <= '{default: '0};
`ifdef STREAMBUF_IN_LAST_EN
            short_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
`ifdef STREAMBUF_IN_LAST_EN
            short_q <= short_d;
`endif
        end
    end

endmodule

// File: tb/tb_streambuf_in.sv
// tb/tb_streambuf_in.sv - scoreboard bench for streambuf_in (DEPTH=4, 16-bit words)
module tb_streambuf_in;

    localparam int DW = 16;
    localparam int AW = 2;
    localparam int FW = 4 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          frame_valid;
    logic [FW-1:0] frame_data;
    logic          frame_ack;
    logic [AW:0]   count;
`ifdef STREAMBUF_IN_LAST_EN
    logic          in_last;
    logic          short_frame;
`endif

    int passed = 0;
    int total  = 0;

    logic [FW-1:0] exp_q [$];
    logic [FW-1:0] build_frame;
    int            widx;
    logic [FW-1:0] exp_f;
    logic [FW-1:0] held;

    streambuf_in #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .frame_valid(frame_valid),
        .frame_data (frame_data),
        .frame_ack  (frame_ack),
`ifdef STREAMBUF_IN_LAST_EN
        .in_last    (in_last),
        .short_frame(short_frame),
`endif
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [FW-1:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    task automatic model_clear();
        build_frame = '0;
        widx        = 0;
        exp_q.delete();
    endtask

    // Drive one word for one edge; the model records it as accepted.
    task automatic push_word(input logic [DW-1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
`ifdef STREAMBUF_IN_LAST_EN
        in_last  = last;
`endif
        tick();
        build_frame[widx*DW +: DW] = d;
        widx++;
`ifdef STREAMBUF_IN_LAST_EN
        if (last && widx < 4) begin
            for (int i = widx; i < 4; i++) build_frame[i*DW +: DW] = '0;
            widx = 4;
        end
        in_last = 1'b0;
`else
        if (last) widx = widx;
`endif
        if (widx == 4) begin
            exp_q.push_back(build_frame);
            widx = 0;
        end
    endtask

    task automatic do_ack();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 16'h5555; frame_ack = 1'b0;
        tick();
        total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_0 act=%b exp=0", in_ready); else passed++;
        tick();
        total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_1 act=%b exp=0", in_ready); else passed++;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        model_clear();
        total++; if (count !== 3'd0) $display("FAIL rst_count act=%0d exp=0", count); else passed++;
        total++; if (frame_valid !== 1'b0) $display("FAIL rst_frame_valid act=%b exp=0", frame_valid); else passed++;
        total++; if (frame_data !== 64'h0) $display("FAIL rst_frame_data act=%h exp=0", frame_data); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready act=%b exp=1", in_ready); else passed++;
    endtask

    task automatic test_full_frame();
        logic [DW-1:0] words [4];
        words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        for (int i = 0; i < 4; i++) begin
            push_word(words[i], 1'b0);
            total++; if (count !== 3'(i + 1)) $display("FAIL full_count%0d act=%0d exp=%0d", i, count, i + 1); else passed++;
        end
        in_valid = 1'b0;
        total++; if (frame_valid !== 1'b1) $display("FAIL full_frame_valid act=%b exp=1", frame_valid); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL full_in_ready act=%b exp=0", in_ready); else passed++;
        exp_f = pop_exp();
        total++; if (frame_data !== exp_f || exp_f !== 64'h4444_3333_2222_1111)
            $display("FAIL full_frame_data act=%h exp=%h", frame_data, 64'h4444_3333_2222_1111); else passed++;
        held = exp_f;
    endtask

    task automatic test_hold_ack();
        in_valid = 1'b1; in_data = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (frame_data !== held || frame_valid !== 1'b1 || count !== 3'd4)
                $display("FAIL hold_cycle%0d act=%h/%b/%0d exp=%h/1/4", i, frame_data, frame_valid, count, held); else passed++;
        end
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        total++; if (frame_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1)
            $display("FAIL ack_release act=%b/%0d/%b exp=0/0/1", frame_valid, count, in_ready); else passed++;
        push_word(16'hDEAD, 1'b0);
        in_valid = 1'b0;
        total++; if (count !== 3'd1) $display("FAIL ack_next_count act=%0d exp=1", count); else passed++;
        total++; if (frame_data !== 64'h4444_3333_2222_DEAD)
            $display("FAIL ack_next_data act=%h exp=%h", frame_data, 64'h4444_3333_2222_DEAD); else passed++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_clear();
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 4; i++) begin
            push_word(16'h0100 + 16'(i), 1'b0);
            in_valid = 1'b0;
            total++; if (count !== 3'(i + 1)) $display("FAIL gap_acc_count%0d act=%0d exp=%0d", i, count, i + 1); else passed++;
            if (i < 3) begin
                tick();
                total++; if (count !== 3'(i + 1) || frame_valid !== 1'b0)
                    $display("FAIL gap_idle_count%0d act=%0d/%b exp=%0d/0", i, count, frame_valid, i + 1); else passed++;
            end
        end
        total++; if (frame_valid !== 1'b1) $display("FAIL gap_frame_valid act=%b exp=1", frame_valid); else passed++;
        exp_f = pop_exp();
        total++; if (frame_data !== exp_f) $display("FAIL gap_frame_data act=%h exp=%h", frame_data, exp_f); else passed++;
        do_ack();
    endtask

    task automatic test_mid_reset();
        push_word(16'hA001, 1'b0);
        push_word(16'hA002, 1'b0);
        in_valid = 1'b0;
        do_ack();
        total++; if (count !== 3'd2 || frame_valid !== 1'b0)
            $display("FAIL fill_ack_ignored act=%0d/%b exp=2/0", count, frame_valid); else passed++;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        model_clear();
        total++; if (count !== 3'd0 || frame_data !== 64'h0 || frame_valid !== 1'b0)
            $display("FAIL midrst_clear act=%0d/%h/%b exp=0/0/0", count, frame_data, frame_valid); else passed++;
        for (int i = 0; i < 4; i++) begin
            push_word(16'hC000 + 16'(i * 3 + 7), 1'b0);
            total++; if (frame_valid !== (i == 3))
                $display("FAIL midrst_fv%0d act=%b exp=%b", i, frame_valid, (i == 3)); else passed++;
        end
        in_valid = 1'b0;
        exp_f = pop_exp();
        total++; if (frame_data !== exp_f) $display("FAIL midrst_frame_data act=%h exp=%h", frame_data, exp_f); else passed++;
        do_ack();
        total++; if (exp_q.size() != 0) $display("FAIL scoreboard_left act=%0d exp=0", exp_q.size()); else passed++;
    endtask

`ifdef STREAMBUF_IN_LAST_EN
    task automatic test_short_frame();
        push_word(16'hAAAA, 1'b0);
        push_word(16'hBBBB, 1'b1);
        in_valid = 1'b0;
        total++; if (frame_valid !== 1'b1 || short_frame !== 1'b1 || count !== 3'd4)
            $display("FAIL short_state act=%b/%b/%0d exp=1/1/4", frame_valid, short_frame, count); else passed++;
        exp_f = pop_exp();
        total++; if (frame_data !== exp_f || exp_f !== 64'h0000_0000_BBBB_AAAA)
            $display("FAIL short_data act=%h exp=%h", frame_data, 64'h0000_0000_BBBB_AAAA); else passed++;
        do_ack();
        total++; if (short_frame !== 1'b0 || frame_valid !== 1'b0)
            $display("FAIL short_ack act=%b/%b exp=0/0", short_frame, frame_valid); else passed++;
        for (int i = 0; i < 4; i++) push_word(16'hE000 + 16'(i), (i == 3));
        in_valid = 1'b0;
        exp_f = pop_exp();
        total++; if (frame_valid !== 1'b1 || short_frame !== 1'b0 || frame_data !== exp_f)
            $display("FAIL last_on_full act=%b/%b/%h exp=1/0/%h", frame_valid, short_frame, frame_data, exp_f); else passed++;
        do_ack();
    endtask
`endif

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; frame_ack = 1'b0;
`ifdef STREAMBUF_IN_LAST_EN
        in_last = 1'b0;
`endif
        model_clear();
        test_reset();
        test_full_frame();
        test_hold_ack();
        test_gapped();
        test_mid_reset();
`ifdef STREAMBUF_IN_LAST_EN
        test_short_frame();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/streambuf_in.md
# streambuf_in

Input-side stream buffer for the LDPC datapath: collects a frame of `2**ADDR_WIDTH` words, one per valid/ready handshake, from the upstream source (host/UART deserialiser). It then presents the whole frame in parallel to the encoder/decoder core. It is the receive-side counterpart of the output stream buffer, which serialises core results back out. It holds the frame stable until the core acknowledges it, then re-arms for the next frame.

## Interface
- `DATA_WIDTH`, 16, width of one stream word.
- `ADDR_WIDTH`, 2, log2 of frame depth; `DEPTH = 2**ADDR_WIDTH` words per frame.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream word present on `in_data`.
- `in_data`  in  DATA_WIDTH  upstream word.
- `in_ready`  out  1  buffer accepts a word this cycle.
- `frame_valid`  out  1  complete frame held on `frame_data`.
- `frame_data`  out  DEPTH*DATA_WIDTH  word i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `frame_ack`  in  1  core has consumed the frame; sampled only while `frame_valid`=1.
- `count`  out  ADDR_WIDTH+1  number of words currently held (0..DEPTH).

## Operation
- Two-state FSM: FILL, HOLD.
- FILL:
  - `in_ready`=1, `frame_valid`=0.
  - On an accept (`in_valid`&&`in_ready`) at an edge: `mem[wptr]<=in_data`, `wptr`++, `count`++.
  - An accept with `wptr`==DEPTH-1 moves the FSM to HOLD; `wptr` wraps to 0.
- HOLD:
  - `in_ready`=0, `frame_valid`=1, `count`=DEPTH.
  - `in_valid` is ignored and memory is not written.
  - `frame_ack`=1 at an edge moves the FSM to FILL with `count`<=0.
  - Memory is not cleared on ack; it is overwritten by the next frame.
- `frame_ack` while in FILL has no effect.
- `frame_data` is driven directly from the memory registers. It changes only on accepted writes, so it is stable throughout HOLD.
- `in_ready` is combinational: `(state==FILL) && rst`. It is never high while reset is asserted.
- Reset (`rst`=0 at an edge):
  - state<=FILL, `wptr`<=0, `count`<=0, all memory words <=0.
  - Outputs after reset: `frame_valid`=0, `frame_data`=0, `count`=0, `in_ready`=1.
- Reset mid-frame or in HOLD discards partial and held data unconditionally. No frame is presented for the discarded data.

## Timing
- Accept latency: a word accepted at edge N is visible on `frame_data` after edge N.
- Frame latency: last word accepted at edge N → `frame_valid`=1 and `in_ready`=0 from edge N onward. No idle cycle is inserted.
- Ack latency: `frame_ack` sampled at edge M → `frame_valid`=0 and `in_ready`=1 after M. The first word of the next frame can be accepted at edge M+1.
- Max throughput is DEPTH words per DEPTH+1 cycles when the core acks in the first HOLD cycle.
- Back-to-back `in_valid` with no gaps fills a frame in exactly DEPTH cycles.
- Gaps in `in_valid` stall `wptr`; the partial frame waits indefinitely.

## Configuration
- `STREAMBUF_IN_LAST_EN`
  - Defined: adds input `in_last` (1) and output `short_frame` (1).
    - An accept with `in_last`=1 and `wptr`<DEPTH-1 stores the word, zero-fills the remaining words on the same edge, and enters HOLD with `count`=DEPTH.
    - In that case `short_frame`=1 for the whole HOLD.
    - `in_last` on the DEPTH-1 word is a normal full frame with `short_frame`=0.
    - `short_frame` clears on ack and on reset.
  - Undefined: ports absent; frames close only on the DEPTH-th word.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with `in_valid`=1 → `in_ready`=0 during reset, then `count`=0, `frame_valid`=0, `frame_data`=0, `in_ready`=1 after release.
- Full frame, DEPTH=4: stream 0x1111, 0x2222, 0x3333, 0x4444 back-to-back → `frame_valid`=1 right after the 4th accept; `frame_data`=0x4444_3333_2222_1111; `in_ready`=0.
- Hold/ack: keep `in_valid`=1 with 0xDEAD for 5 cycles in HOLD → `frame_data` unchanged. Pulse `frame_ack` → next edge `frame_valid`=0, `count`=0; 0xDEAD is accepted as word 0 on the following edge.
- Gapped input: valid on alternate cycles → `count` steps 1,1,2,2,3,3,4 and the frame completes after the 4th accept.
- Mid-frame reset: accept 2 words, assert `rst`=0 → `count`=0, memory zeroed, and no `frame_valid` pulse. The next 4 words form a clean frame.
- (`STREAMBUF_IN_LAST_EN`) send 0xAAAA, then 0xBBBB with `in_last`=1 → `frame_valid`=1, `short_frame`=1, `frame_data`=0x0000_0000_BBBB_AAAA.
